// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: shares one pipelined multiplier among NUM_REQ requesters.
// A round-robin arbiter issues at most one multiply per cycle. A one-hot tag
// travels alongside each operation for MULT_LATENCY cycles and steers the
// product back to its requester as a one-cycle response strobe.
// Optional performance counters are built when MULT_SHARE_ARB_PERF_EN is defined;
// otherwise perf_issued and perf_conflict are tied to zero.
//
// Handshake: an operation is accepted in any cycle where req_valid[i] and
// req_ready[i] are both high. req_ready is a combinational one-hot grant and
// never depends on anything the requester does in response to it. Requesters
// may withdraw req_valid at any time. Responses cannot be stalled: resp_valid[i]
// is high for exactly one cycle, and the requester must take resp_out in that cycle.
module mult_share_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int WIDTH        = 32,
    parameter int MULT_LATENCY = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_in1,
    input  logic [NUM_REQ*WIDTH-1:0] req_in2,
    output logic [NUM_REQ-1:0]       resp_valid,
    output logic [WIDTH-1:0]         resp_out,
    output logic                     busy,
    output logic [WIDTH-1:0]         mult_in1,
    output logic [WIDTH-1:0]         mult_in2,
    output logic                     mult_tstart,
    input  logic [WIDTH-1:0]         mult_out,
    output logic [31:0]              perf_issued,
    output logic [31:0]              perf_conflict
);

    // A single requester still gets a 1-bit pointer; it simply never leaves 0.
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0] grant_idx;
    logic             grant_found;
    logic             accept;

    logic [MULT_LATENCY-1:0][NUM_REQ-1:0] tag_q, tag_d;

    // Round-robin search starting at rr_ptr. The first valid requester wins.
    always_comb begin : arb_search
        int idx;
        idx         = 0;
        grant_idx   = '0;
        grant_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_idx   = PTR_W'(idx);
            end
        end
    end

    // Grant, operand mux and issue strobe. All outputs are zero when nothing is granted.
    always_comb begin
        req_ready = '0;
        mult_in1  = '0;
        mult_in2  = '0;
        if (en && grant_found) begin
            req_ready[grant_idx] = 1'b1;
            mult_in1 = req_in1[int'(grant_idx)*WIDTH +: WIDTH];
            mult_in2 = req_in2[int'(grant_idx)*WIDTH +: WIDTH];
        end
        accept      = |(req_ready & req_valid);
        mult_tstart = |req_ready;
    end

    // Pointer moves just past the winner on acceptance and holds otherwise.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            if (int'(grant_idx) == NUM_REQ - 1) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx + PTR_W'(1);
            end
        end
    end

    // Tag shift register matching the multiplier latency. Stage 0 is zero on idle cycles.
    always_comb begin
        tag_d    = tag_q;
        tag_d[0] = req_ready & req_valid;
        for (int k = 1; k < MULT_LATENCY; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    // Arbiter pointer and tag pipeline registers. Reset discards in-flight tags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= '0;
            tag_q    <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
            tag_q    <= tag_d;
        end
    end

    assign resp_valid = tag_q[MULT_LATENCY-1];
    assign resp_out   = mult_out;
    assign busy       = |tag_q;

`ifdef MULT_SHARE_ARB_PERF_EN
    logic [31:0] perf_issued_q, perf_issued_d;
    logic [31:0] perf_conflict_q, perf_conflict_d;
    logic [$clog2(NUM_REQ+1)-1:0] valid_count;

    // Saturating counters: issued operations, and cycles with two or more requests.
    always_comb begin
        valid_count = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            valid_count = valid_count + {{($clog2(NUM_REQ+1)-1){1'b0}}, req_valid[k]};
        end
        perf_issued_d   = perf_issued_q;
        perf_conflict_d = perf_conflict_q;
        if (accept && (perf_issued_q != 32'hFFFF_FFFF)) begin
            perf_issued_d = perf_issued_q + 32'd1;
        end
        if ((int'(valid_count) >= 2) && (perf_conflict_q != 32'hFFFF_FFFF)) begin
            perf_conflict_d = perf_conflict_q + 32'd1;
        end
    end

    // Performance counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issued_q   <= '0;
            perf_conflict_q <= '0;
        end else begin
            perf_issued_q   <= perf_issued_d;
            perf_conflict_q <= perf_conflict_d;
        end
    end

    assign perf_issued   = perf_issued_q;
    assign perf_conflict = perf_conflict_q;
`else
    assign perf_issued   = '0;
    assign perf_conflict = '0;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Bench for mult_share_arbiter with a behavioural 2-cycle multiplier.
// The driver pushes {due cycle, one-hot tag, product} for each accepted op.
// The monitor pops and compares whenever resp_valid is non-zero.
module tb_mult_share_arbiter;
  localparam int N  = 4;
  localparam int W  = 32;
  localparam int EW = 32 + N + W;

  logic             clk;
  logic             rst;
  logic             en;
  logic [N-1:0]     req_valid;
  logic [N-1:0]     req_ready;
  logic [N*W-1:0]   req_in1;
  logic [N*W-1:0]   req_in2;
  logic [N-1:0]     resp_valid;
  logic [W-1:0]     resp_out;
  logic             busy;
  logic [W-1:0]     mult_in1;
  logic [W-1:0]     mult_in2;
  logic             mult_tstart;
  logic [W-1:0]     mult_out;
  logic [31:0]      perf_issued;
  logic [31:0]      perf_conflict;

  logic [31:0]      cyc;
  logic [W-1:0]     mul_p1;
  logic [W-1:0]     mul_p2;
  logic [EW-1:0]    exp_q[$];
  logic [EW-1:0]    mon_e;
  int               checks;
  int               errors;

  mult_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .MULT_LATENCY(2)) dut (
    .clk(clk), .rst(rst), .en(en),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_in1(req_in1), .req_in2(req_in2),
    .resp_valid(resp_valid), .resp_out(resp_out), .busy(busy),
    .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_tstart(mult_tstart),
    .mult_out(mult_out),
    .perf_issued(perf_issued), .perf_conflict(perf_conflict)
  );

  // clock / cycle counter / shared multiplier model
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 32'd1;
    mul_p1 <= mult_in1 * mult_in2;
    mul_p2 <= mul_p1;
  end
  assign mult_out = mul_p2;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in1[i*W +: W] = a;
    req_in2[i*W +: W] = b;
  endtask

  // drive one cycle and check the combinational grant path; queue the expected response
  task automatic step(input logic [N-1:0] v, input logic e, input logic [N-1:0] x_ready,
                      input logic [W-1:0] x_in1, input logic [W-1:0] x_in2,
                      input logic [W-1:0] x_prod, input logic x_busy);
    @(negedge clk);
    req_valid = v;
    en        = e;
    #1;
    chk("req_ready", 64'(req_ready), 64'(x_ready));
    chk("mult_tstart", 64'(mult_tstart), 64'(|x_ready));
    chk("mult_in1", 64'(mult_in1), 64'(x_in1));
    chk("mult_in2", 64'(mult_in2), 64'(x_in2));
    chk("busy", 64'(busy), 64'(x_busy));
    if (x_ready != '0) exp_q.push_back({cyc + 32'd2, x_ready, x_prod});
  endtask

  // monitor: pop and compare on every response strobe; flag overdue responses
  always @(negedge clk) begin
    if (!rst) begin
      if (resp_valid != '0) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL resp_unexpected actual=%b/%0d required=none (cycle %0d)", resp_valid, resp_out, cyc);
        end else begin
          mon_e = exp_q.pop_front();
          chk("resp_cycle", 64'(cyc), 64'(mon_e[EW-1 -: 32]));
          chk("resp_valid", 64'(resp_valid), 64'(mon_e[W +: N]));
          chk("resp_out", 64'(resp_out), 64'(mon_e[W-1:0]));
        end
      end else if (exp_q.size() > 0 && exp_q[0][EW-1 -: 32] <= cyc) begin
        checks++;
        errors++;
        mon_e = exp_q.pop_front();
        $display("FAIL resp_missing actual=none required=%b/%0d (cycle %0d)", mon_e[W +: N], mon_e[W-1:0], cyc);
      end
    end
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 32'd0;
    rst       = 1'b1;
    en        = 1'b0;
    req_valid = '0;
    req_in1   = '0;
    req_in2   = '0;
    // requester i: in1 = i+2, in2 = i+3 -> products 6, 12, 20, 30
    set_ops(0, 32'd2, 32'd3);
    set_ops(1, 32'd3, 32'd4);
    set_ops(2, 32'd4, 32'd5);
    set_ops(3, 32'd5, 32'd6);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_perf_issued", 64'(perf_issued), 64'd0);
    chk("rst_perf_conflict", 64'(perf_conflict), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // all-valid fairness from reset: 0,1,2,3,0,1,2,3
    step(4'b1111, 1'b1, 4'b0001, 32'd2, 32'd3, 32'd6,  1'b0);
    step(4'b1111, 1'b1, 4'b0010, 32'd3, 32'd4, 32'd12, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 32'd4, 32'd5, 32'd20, 1'b1);
    step(4'b1111, 1'b1, 4'b1000, 32'd5, 32'd6, 32'd30, 1'b1);
    step(4'b1111, 1'b1, 4'b0001, 32'd2, 32'd3, 32'd6,  1'b1);
    step(4'b1111, 1'b1, 4'b0010, 32'd3, 32'd4, 32'd12, 1'b1);
    step(4'b1111, 1'b1, 4'b0100, 32'd4, 32'd5, 32'd20, 1'b1);
    step(4'b1111, 1'b1, 4'b1000, 32'd5, 32'd6, 32'd30, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b0);

    // single op: 7 * 6 = 42 to requester 1, busy for two cycles
    set_ops(1, 32'd7, 32'd6);
    step(4'b0010, 1'b1, 4'b0010, 32'd7, 32'd6, 32'd42, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b0);
    set_ops(1, 32'd3, 32'd4);

    // pointer wrap/skip: grant 2 -> ptr 3, then 0011 gives 0 then 1
    step(4'b0100, 1'b1, 4'b0100, 32'd4, 32'd5, 32'd20, 1'b0);
    step(4'b0011, 1'b1, 4'b0001, 32'd2, 32'd3, 32'd6,  1'b1);
    step(4'b0011, 1'b1, 4'b0010, 32'd3, 32'd4, 32'd12, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b0);

    // en gating, then en dropped mid-stream while the pipeline drains (ptr is 2)
    step(4'b0100, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b0);
    step(4'b0100, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b0);
    step(4'b0100, 1'b1, 4'b0100, 32'd4, 32'd5, 32'd20, 1'b0);
    step(4'b1111, 1'b1, 4'b1000, 32'd5, 32'd6, 32'd30, 1'b1);
    step(4'b1111, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
    step(4'b1111, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
    step(4'b0000, 1'b0, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b0);

    // reset mid-flight: op accepted, rst next cycle, no strobe may appear (ptr is 0)
    @(negedge clk);
    req_valid = 4'b0001;
    en        = 1'b1;
    #1;
    chk("rstflight_grant", 64'(req_ready), 64'b0001);
    @(negedge clk);
    req_valid = 4'b0000;
    rst       = 1'b1;
    #1;
    chk("rstflight_busy", 64'(busy), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);
    // pointer was 1 before reset; after reset 0011 must grant 0
    step(4'b0011, 1'b1, 4'b0001, 32'd2, 32'd3, 32'd6, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);

    // perf counters: fresh reset, three cycles of 0101
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    step(4'b0101, 1'b1, 4'b0001, 32'd2, 32'd3, 32'd6,  1'b0);
    step(4'b0101, 1'b1, 4'b0100, 32'd4, 32'd5, 32'd20, 1'b1);
    step(4'b0101, 1'b1, 4'b0001, 32'd2, 32'd3, 32'd6,  1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0,  1'b1);
`ifdef MULT_SHARE_ARB_PERF_EN
    chk("perf_issued", 64'(perf_issued), 64'd3);
    chk("perf_conflict", 64'(perf_conflict), 64'd3);
`else
    chk("perf_issued", 64'(perf_issued), 64'd0);
    chk("perf_conflict", 64'(perf_conflict), 64'd0);
`endif
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b1);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);
    step(4'b0000, 1'b1, 4'b0000, 32'd0, 32'd0, 32'd0, 1'b0);

    // every queued response must have been seen
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
